rp_dec_div_arb: RTL and testbench
=================================

# rp_dec_div_arb

Controller that shares one unsigned pipelined divider (XDW/YDW, new operand accepted every ISSUE_GAP cycles, fixed latency) between the two ADC channel decimators. It takes signed sums and decimation factors from channel A and channel B, arbitrates, converts the sums to magnitude, issues them to the divider, tracks in-flight operations with a tag FIFO, and returns signed quotients to the owning channel. It sits between the per-channel accumulators and a single divide instance in the ADC acquisition path.

## Interface
- XDW, 32, dividend/quotient width
- YDW, 17, divisor width
- ISSUE_GAP, 16, minimum cycles between divider issues (≥2)
- TAG_DEPTH, 4, in-flight operation limit (power of two, ≥ ceil(divider latency / ISSUE_GAP)+1)

Ports:
- adc_clk_i  in  1  ADC clock; the only clock
- adc_rstn_i  in  1  reset, asynchronous, active-low
- cha_req_i / chb_req_i  in  1  division request; held until ack
- cha_sum_i / chb_sum_i  in  XDW  signed (two's complement) dividend
- cha_dec_i / chb_dec_i  in  YDW  unsigned divisor
- cha_ack_o / chb_ack_o  out  1  request consumed (1-cycle pulse)
- cha_val_o / chb_val_o  out  1  quotient valid (1-cycle pulse)
- cha_quo_o / chb_quo_o  out  XDW  signed quotient
- div_go_o  out  1  divider start
- div_x_o  out  XDW  unsigned dividend to divider
- div_y_o  out  YDW  divisor to divider
- div_q_i  in  XDW  unsigned quotient from divider
- div_ok_i  in  1  divider result valid
- err_clr_i  in  1  clears err_o
- err_o  out  2  sticky: [0] orphan result, [1] zero divisor

## Operation
- Issue allowed when gap counter = 0 and tag FIFO count < TAG_DEPTH.
- Arbitration (round-robin): if only one req, grant it; if both, grant channel ≠ last granted; last-grant pointer resets to B (A wins first tie).
- Granted divisor ≠ 0: next edge registers div_go_o=1, div_x_o = |sum| (sum<0 → -sum, mod 2^XDW; −2^(XDW−1) → 2^(XDW−1)), div_y_o = dec, ack pulse to granted channel, push tag {ch, neg=sum[XDW−1]}, gap counter ← ISSUE_GAP−1.
- Granted divisor = 0: ack pulse, no issue, no push, no result; err_o[1] ← 1; gap counter not loaded.
- Gap counter decrements to 0 each cycle when nonzero.
- div_ok_i with FIFO non-empty: pop tag; next edge selected channel val_o=1, quo_o = neg ? −div_q_i : div_q_i (mod 2^XDW). Non-selected channel val_o=0, quo_o holds.
- div_ok_i with FIFO empty: result dropped, err_o[0] ← 1.
- Push and pop same cycle: count unchanged; a pop from full in the same cycle does not enable issue that cycle (issue check uses pre-pop count).
- err_clr_i clears both bits; a set event in the same cycle wins.
- Results return in issue order; divider must be in-order.

## Timing
- Reset values: all *_ack_o, *_val_o, div_go_o = 0; *_quo_o, div_x_o, div_y_o = 0; err_o = 0; FIFO empty; gap counter 0.
- Request sampled in cycle N → ack_o/div_go_o high in N+1. Requester drops req or presents the next operation in N+2; gap ≥2 prevents double capture.
- div_ok_i in cycle M → val_o in M+1.
- Back-to-back issue interval exactly ISSUE_GAP cycles under continuous requests.
- Reset mid-operation flushes FIFO; divider must share adc_rstn_i, otherwise stale results are flagged as orphans and dropped.

## Configuration
- RP_DEC_DIV_ARB_FIXPRIO_EN defined: fixed priority, channel A always wins ties; pointer logic removed.
- Undefined: round-robin as above.

## Structure
- Package rp_dec_div_pkg: tag typedef {ch, neg}, channel encoding (A=0, B=1), err_o bit indices.
- Sub-module rp_dec_div_tag_fifo: synchronous FIFO, TAG_DEPTH entries, count output, simultaneous push/pop.

## Test plan
- A only, sum=−1000, dec=100 → div_x_o=1000, div_y_o=100; model returns 10 → cha_val_o pulse, cha_quo_o=−10.
- A and B request continuously → grants alternate A,B,A,…; div_go_o pulses exactly 16 cycles apart.
- Sum = 0x8000_0000, dec=16 → div_x_o=0x8000_0000; quotient 0x0800_0000 → quo_o=0xF800_0000.
- Divider latency 70 with TAG_DEPTH=4 → fifth issue stalls until first div_ok_i; no results lost or misrouted.
- B request with dec=0 → chb_ack_o pulse, no div_go_o, err_o=2'b10; err_clr_i → 0.
- Unsolicited div_ok_i after reset → no val_o, err_o[0]=1.

Source files
------------

// File: rtl/rp_dec_div_pkg.sv
// Shared definitions for the ADC decimator divider arbiter.
//   ch_e         : channel encoding (A=0, B=1)
//   tag_t        : in-flight tag {ch, neg} kept per issued division
//   TAG_W        : packed width of tag_t, used for FIFO ports
//   ERR_ORPHAN   : err_o bit set when a divider result arrives with no tag
//   ERR_ZERO_DIV : err_o bit set when a granted request has divisor 0
package rp_dec_div_pkg;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } ch_e;

  typedef struct packed {
    ch_e  ch;
    logic neg;
  } tag_t;

  localparam int unsigned TAG_W        = $bits(tag_t);
  localparam int unsigned ERR_ORPHAN   = 0;
  localparam int unsigned ERR_ZERO_DIV = 1;

endpackage

// File: rtl/rp_dec_div_tag_fifo.sv
// Synchronous tag FIFO tracking in-flight divider operations.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (flushes FIFO)
//   push_i, push_tag_i : write a tag (ignored when full)
//   pop_i, pop_tag_o   : read/remove head tag (ignored when empty);
//                        pop_tag_o shows the head combinationally
//   count_o            : number of stored tags (0..DEPTH)
// DEPTH must be a power of two, >= 2. Push and pop in the same cycle
// leave the count unchanged.
module rp_dec_div_tag_fifo
  import rp_dec_div_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [TAG_W-1:0]         push_tag_i,
  input  logic                     pop_i,
  output logic [TAG_W-1:0]         pop_tag_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok  = push_i && (count_q != FULL);
    pop_ok   = pop_i && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_tag_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_tag_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/rp_dec_div_arb.sv
// Shares one in-order pipelined unsigned divider between ADC decimator
// channels A and B. Sums are issued as magnitudes; a {ch, neg} tag per
// issue is queued and used to sign and route the returned quotient.
// Ports:
//   adc_clk_i, adc_rstn_i        : clock, asynchronous active-low reset
//   cha_/chb_req_i, _sum_i, _dec_i : request, signed dividend, divisor
//   cha_/chb_ack_o               : request consumed (1-cycle pulse)
//   cha_/chb_val_o, _quo_o       : quotient valid pulse, signed quotient
//   div_go_o, div_x_o, div_y_o   : divider start, |dividend|, divisor
//   div_q_i, div_ok_i            : divider quotient, result valid
//   err_clr_i, err_o             : sticky errors [0] orphan, [1] zero divisor
// Build option: define RP_DEC_DIV_ARB_FIXPRIO_EN for fixed priority
// (A wins ties); otherwise ties are broken round-robin.
module rp_dec_div_arb
  import rp_dec_div_pkg::*;
#(
  parameter int unsigned XDW       = 32,
  parameter int unsigned YDW       = 17,
  parameter int unsigned ISSUE_GAP = 16,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic           adc_clk_i,
  input  logic           adc_rstn_i,
  input  logic           cha_req_i,
  input  logic [XDW-1:0] cha_sum_i,
  input  logic [YDW-1:0] cha_dec_i,
  output logic           cha_ack_o,
  output logic           cha_val_o,
  output logic [XDW-1:0] cha_quo_o,
  input  logic           chb_req_i,
  input  logic [XDW-1:0] chb_sum_i,
  input  logic [YDW-1:0] chb_dec_i,
  output logic           chb_ack_o,
  output logic           chb_val_o,
  output logic [XDW-1:0] chb_quo_o,
  output logic           div_go_o,
  output logic [XDW-1:0] div_x_o,
  output logic [YDW-1:0] div_y_o,
  input  logic [XDW-1:0] div_q_i,
  input  logic           div_ok_i,
  input  logic           err_clr_i,
  output logic [1:0]     err_o
);

  localparam int unsigned GW = $clog2(ISSUE_GAP);
  localparam int unsigned CW = $clog2(TAG_DEPTH) + 1;
  localparam logic [GW-1:0] GAP_LOAD  = GW'(ISSUE_GAP - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(TAG_DEPTH);

  logic [GW-1:0]  gap_q, gap_d;
  logic           ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic           val_a_q, val_a_d, val_b_q, val_b_d;
  logic [XDW-1:0] quo_a_q, quo_a_d, quo_b_q, quo_b_d;
  logic           go_q, go_d;
  logic [XDW-1:0] x_q, x_d;
  logic [YDW-1:0] y_q, y_d;
  logic [1:0]     err_q, err_d;

  logic           issue_ok, req_a, req_b, gnt_a, gnt_b, gnt_any;
  logic [XDW-1:0] gnt_sum, gnt_abs, quo_signed;
  logic [YDW-1:0] gnt_dec;
  logic           dec_zero, issue, pop;
  tag_t           push_tag, head_tag;
  logic [TAG_W-1:0] head_bits;
  logic [CW-1:0]  fifo_cnt;

`ifndef RP_DEC_DIV_ARB_FIXPRIO_EN
  ch_e last_q, last_d;
`endif

  always_comb begin
    // FIFO check uses the pre-pop count: a pop from full cannot free a slot
    // for an issue in the same cycle.
    issue_ok = (gap_q == '0) && (fifo_cnt < FIFO_FULL);
    // A channel acked last cycle still holds req; it must not be re-granted
    // (matters for zero-divisor grants, which do not load the gap counter).
    req_a = cha_req_i && !ack_a_q;
    req_b = chb_req_i && !ack_b_q;
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (issue_ok) begin
      if (req_a && req_b) begin
`ifdef RP_DEC_DIV_ARB_FIXPRIO_EN
        gnt_a = 1'b1;
`else
        if (last_q == CH_B) gnt_a = 1'b1;
        else                gnt_b = 1'b1;
`endif
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
    gnt_any  = gnt_a || gnt_b;
    gnt_sum  = gnt_b ? chb_sum_i : cha_sum_i;
    gnt_dec  = gnt_b ? chb_dec_i : cha_dec_i;
    gnt_abs  = gnt_sum[XDW-1] ? (~gnt_sum + XDW'(1)) : gnt_sum;
    dec_zero = (gnt_dec == '0);
    issue    = gnt_any && !dec_zero;

    push_tag.ch  = gnt_b ? CH_B : CH_A;
    push_tag.neg = gnt_sum[XDW-1];

    head_tag   = tag_t'(head_bits);
    pop        = div_ok_i && (fifo_cnt != '0);
    quo_signed = head_tag.neg ? (~div_q_i + XDW'(1)) : div_q_i;

    ack_a_d = gnt_a;
    ack_b_d = gnt_b;
    go_d    = issue;
    x_d     = issue ? gnt_abs : x_q;
    y_d     = issue ? gnt_dec : y_q;

    if (issue)              gap_d = GAP_LOAD;
    else if (gap_q != '0)   gap_d = gap_q - GW'(1);
    else                    gap_d = gap_q;

    val_a_d = pop && (head_tag.ch == CH_A);
    val_b_d = pop && (head_tag.ch == CH_B);
    quo_a_d = val_a_d ? quo_signed : quo_a_q;
    quo_b_d = val_b_d ? quo_signed : quo_b_q;

    // Clear first so a set event in the same cycle wins.
    err_d = err_q;
    if (err_clr_i) err_d = '0;
    if (div_ok_i && !pop)     err_d[ERR_ORPHAN]   = 1'b1;
    if (gnt_any && dec_zero)  err_d[ERR_ZERO_DIV] = 1'b1;

`ifndef RP_DEC_DIV_ARB_FIXPRIO_EN
    last_d = last_q;
    if (gnt_a)      last_d = CH_A;
    else if (gnt_b) last_d = CH_B;
`endif
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      gap_q   <= '0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      val_a_q <= 1'b0;
      val_b_q <= 1'b0;
      quo_a_q <= '0;
      quo_b_q <= '0;
      go_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= '0;
    end else begin
      gap_q   <= gap_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      val_a_q <= val_a_d;
      val_b_q <= val_b_d;
      quo_a_q <= quo_a_d;
      quo_b_q <= quo_b_d;
      go_q    <= go_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

`ifndef RP_DEC_DIV_ARB_FIXPRIO_EN
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) last_q <= CH_B;
    else             last_q <= last_d;
  end
`endif

  rp_dec_div_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk_i      (adc_clk_i),
    .rst_ni     (adc_rstn_i),
    .push_i     (issue),
    .push_tag_i (push_tag),
    .pop_i      (pop),
    .pop_tag_o  (head_bits),
    .count_o    (fifo_cnt)
  );

  assign cha_ack_o = ack_a_q;
  assign chb_ack_o = ack_b_q;
  assign cha_val_o = val_a_q;
  assign chb_val_o = val_b_q;
  assign cha_quo_o = quo_a_q;
  assign chb_quo_o = quo_b_q;
  assign div_go_o  = go_q;
  assign div_x_o   = x_q;
  assign div_y_o   = y_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_rp_dec_div_arb.sv
module tb_rp_dec_div_arb;

  logic        clk = 1'b0;
  logic        adc_rstn_i;
  logic        cha_req_i, chb_req_i;
  logic [31:0] cha_sum_i, chb_sum_i;
  logic [16:0] cha_dec_i, chb_dec_i;
  logic        cha_ack_o, chb_ack_o, cha_val_o, chb_val_o;
  logic [31:0] cha_quo_o, chb_quo_o;
  logic        div_go_o;
  logic [31:0] div_x_o;
  logic [16:0] div_y_o;
  logic [31:0] div_q_i;
  logic        div_ok_i;
  logic        err_clr_i;
  logic [1:0]  err_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 20;
  logic [31:0] pend_q[$];
  int          due_q[$];
  int          go_cyc[$];

  always #5 clk = ~clk;

  rp_dec_div_arb #(.XDW(32), .YDW(17), .ISSUE_GAP(16), .TAG_DEPTH(4)) dut (
    .adc_clk_i(clk), .adc_rstn_i(adc_rstn_i),
    .cha_req_i(cha_req_i), .cha_sum_i(cha_sum_i), .cha_dec_i(cha_dec_i),
    .cha_ack_o(cha_ack_o), .cha_val_o(cha_val_o), .cha_quo_o(cha_quo_o),
    .chb_req_i(chb_req_i), .chb_sum_i(chb_sum_i), .chb_dec_i(chb_dec_i),
    .chb_ack_o(chb_ack_o), .chb_val_o(chb_val_o), .chb_quo_o(chb_quo_o),
    .div_go_o(div_go_o), .div_x_o(div_x_o), .div_y_o(div_y_o),
    .div_q_i(div_q_i), .div_ok_i(div_ok_i),
    .err_clr_i(err_clr_i), .err_o(err_o)
  );

  // Reference arithmetic on plain integers.
  function automatic logic [31:0] ref_abs(input logic [31:0] s);
    longint v;
    v = longint'($signed(s));
    if (v < 0) v = -v;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_quo(input logic [31:0] s, input logic [16:0] d);
    longint v, m, q;
    v = longint'($signed(s));
    m = (v < 0) ? -v : v;
    q = m / longint'(d);
    if (v < 0) q = -q;
    return q[31:0];
  endfunction

  // One clock; also acts as an in-order divider with latency 'lat'.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (div_go_o) begin
      go_cyc.push_back(cyc);
      pend_q.push_back(div_x_o / {15'd0, div_y_o});
      due_q.push_back(cyc + lat);
    end
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      div_ok_i = 1'b1;
      div_q_i  = pend_q.pop_front();
      void'(due_q.pop_front());
    end else begin
      div_ok_i = 1'b0;
      div_q_i  = $urandom;
    end
  endtask

  task automatic reset_dut();
    adc_rstn_i = 1'b0;
    cha_req_i = 0; chb_req_i = 0;
    cha_sum_i = 0; chb_sum_i = 0; cha_dec_i = 0; chb_dec_i = 0;
    div_ok_i = 0; div_q_i = 0; err_clr_i = 0;
    pend_q.delete(); due_q.delete(); go_cyc.delete();
    repeat (3) @(posedge clk);
    #1;
    adc_rstn_i = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    reset_dut();
    cha_sum_i = -32'sd5; cha_dec_i = 17'd1; cha_req_i = 1'b1;
    step();
    #2;
    adc_rstn_i = 1'b0;
    #1;
    checks++; if (cha_ack_o !== 1'b0) begin errors++; $display("FAIL rst_cha_ack got %b exp 0", cha_ack_o); end
    checks++; if (chb_ack_o !== 1'b0) begin errors++; $display("FAIL rst_chb_ack got %b exp 0", chb_ack_o); end
    checks++; if (cha_val_o !== 1'b0) begin errors++; $display("FAIL rst_cha_val got %b exp 0", cha_val_o); end
    checks++; if (chb_val_o !== 1'b0) begin errors++; $display("FAIL rst_chb_val got %b exp 0", chb_val_o); end
    checks++; if (div_go_o !== 1'b0) begin errors++; $display("FAIL rst_go got %b exp 0", div_go_o); end
    checks++; if (div_x_o !== 32'd0) begin errors++; $display("FAIL rst_div_x got %h exp 0", div_x_o); end
    checks++; if (div_y_o !== 17'd0) begin errors++; $display("FAIL rst_div_y got %h exp 0", div_y_o); end
    checks++; if (cha_quo_o !== 32'd0 || chb_quo_o !== 32'd0) begin errors++; $display("FAIL rst_quo got %h/%h exp 0", cha_quo_o, chb_quo_o); end
    checks++; if (err_o !== 2'b00) begin errors++; $display("FAIL rst_err got %b exp 00", err_o); end
  endtask

  task automatic test_single_a();
    logic [31:0] s;
    logic [16:0] d;
    bit seen;
    reset_dut();
    lat = 20;
    s = -32'sd1000; d = 17'd100;
    cha_sum_i = s; cha_dec_i = d; cha_req_i = 1'b1;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      step();
      if (cha_ack_o) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL single_ack got none exp pulse"); end
    checks++; if (div_go_o !== 1'b1) begin errors++; $display("FAIL single_go got %b exp 1", div_go_o); end
    checks++; if (div_x_o !== ref_abs(s)) begin errors++; $display("FAIL single_x got %0d exp %0d", div_x_o, ref_abs(s)); end
    checks++; if (div_y_o !== d) begin errors++; $display("FAIL single_y got %0d exp %0d", div_y_o, d); end
    checks++; if (chb_ack_o !== 1'b0) begin errors++; $display("FAIL single_chb_ack got %b exp 0", chb_ack_o); end
    step();
    cha_req_i = 1'b0;
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      step();
      if (cha_val_o || chb_val_o) seen = 1;
    end
    checks++; if (!seen || cha_val_o !== 1'b1) begin errors++; $display("FAIL single_val got %b exp 1", cha_val_o); end
    checks++; if (cha_quo_o !== ref_quo(s, d)) begin errors++; $display("FAIL single_quo got %h exp %h", cha_quo_o, ref_quo(s, d)); end
    checks++; if (chb_val_o !== 1'b0) begin errors++; $display("FAIL single_chb_val got %b exp 0", chb_val_o); end
    checks++; if (err_o !== 2'b00) begin errors++; $display("FAIL single_err got %b exp 00", err_o); end
  endtask

  task automatic test_min_neg();
    logic [31:0] s;
    logic [16:0] d;
    bit seen;
    reset_dut();
    lat = 5;
    s = 32'h8000_0000; d = 17'd16;
    chb_sum_i = s; chb_dec_i = d; chb_req_i = 1'b1;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      step();
      if (chb_ack_o) seen = 1;
    end
    checks++; if (!seen || div_x_o !== 32'h8000_0000) begin errors++; $display("FAIL minneg_x got %h exp 80000000", div_x_o); end
    step();
    chb_req_i = 1'b0;
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      step();
      if (cha_val_o || chb_val_o) seen = 1;
    end
    checks++; if (chb_val_o !== 1'b1 || cha_val_o !== 1'b0) begin errors++; $display("FAIL minneg_val got a=%b b=%b exp a=0 b=1", cha_val_o, chb_val_o); end
    checks++; if (chb_quo_o !== ref_quo(s, d)) begin errors++; $display("FAIL minneg_quo got %h exp %h", chb_quo_o, ref_quo(s, d)); end
  endtask

  task automatic test_zero_div();
    int gos, vals;
    bit seen;
    reset_dut();
    lat = 5;
    chb_sum_i = $urandom; chb_dec_i = 17'd0; chb_req_i = 1'b1;
    seen = 0; gos = 0; vals = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      step();
      if (chb_ack_o) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL zdiv_ack got none exp pulse"); end
    checks++; if (div_go_o !== 1'b0) begin errors++; $display("FAIL zdiv_go got %b exp 0", div_go_o); end
    step();
    chb_req_i = 1'b0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (div_go_o) gos++;
      if (cha_val_o || chb_val_o) vals++;
    end
    checks++; if (gos != 0 || vals != 0) begin errors++; $display("FAIL zdiv_quiet got go=%0d val=%0d exp 0/0", gos, vals); end
    checks++; if (err_o !== 2'b10) begin errors++; $display("FAIL zdiv_err got %b exp 10", err_o); end
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    checks++; if (err_o !== 2'b00) begin errors++; $display("FAIL zdiv_clr got %b exp 00", err_o); end
  endtask

  task automatic test_orphan();
    reset_dut();
    step();
    div_ok_i = 1'b1;
    div_q_i  = 32'd123;
    step();
    step();
    checks++; if (cha_val_o !== 1'b0 || chb_val_o !== 1'b0) begin errors++; $display("FAIL orphan_val got a=%b b=%b exp 0", cha_val_o, chb_val_o); end
    checks++; if (err_o !== 2'b01) begin errors++; $display("FAIL orphan_err got %b exp 01", err_o); end
  endtask

  // Both channels stream n operations each with random operands.
  task automatic run_stream(input int l, input int n, input bit chk_gap);
    logic [31:0] as[$], bs[$];
    logic [16:0] ad[$], bd[$];
    int ia, ib, ga, gb, acks, last;
    bit adv_a, adv_b, drv_a, drv_b, done;
    reset_dut();
    lat = l;
    for (int i = 0; i < n; i++) begin
      as.push_back($urandom); ad.push_back(17'($urandom_range(1, 131071)));
      bs.push_back($urandom); bd.push_back(17'($urandom_range(1, 131071)));
    end
    ia = 0; ib = 0; ga = 0; gb = 0; acks = 0; last = -1;
    adv_a = 0; adv_b = 0; done = 0;
    drv_a = 1; drv_b = 1;
    cha_req_i = 1; cha_sum_i = as[0]; cha_dec_i = ad[0];
    chb_req_i = 1; chb_sum_i = bs[0]; chb_dec_i = bd[0];
    for (int t = 0; t < 3000 && !done; t++) begin
      step();
      if (adv_a) begin ia++; adv_a = 0; end
      if (adv_b) begin ib++; adv_b = 0; end
      if (cha_ack_o && chb_ack_o) begin
        checks++; errors++; $display("FAIL stream_dual_ack got both exp one");
      end else if (cha_ack_o || chb_ack_o) begin
        acks++;
        checks++;
        if (drv_a && drv_b && (last == (cha_ack_o ? 0 : 1))) begin
          errors++; $display("FAIL stream_rr got ch%0d twice exp alternate", last);
        end
        checks++;
        if (div_go_o !== 1'b1 ||
            div_x_o !== ref_abs(cha_ack_o ? as[ia] : bs[ib]) ||
            div_y_o !== (cha_ack_o ? ad[ia] : bd[ib])) begin
          errors++;
          $display("FAIL stream_issue got go=%b x=%h y=%h exp go=1 x=%h y=%h", div_go_o, div_x_o, div_y_o,
                   ref_abs(cha_ack_o ? as[ia] : bs[ib]), cha_ack_o ? ad[ia] : bd[ib]);
        end
        last = cha_ack_o ? 0 : 1;
        if (cha_ack_o) adv_a = 1; else adv_b = 1;
      end
      if (cha_val_o) begin
        checks++;
        if (ga >= n) begin errors++; $display("FAIL stream_extra_a got %h exp none", cha_quo_o); end
        else if (cha_quo_o !== ref_quo(as[ga], ad[ga])) begin
          errors++; $display("FAIL stream_quo_a[%0d] got %h exp %h", ga, cha_quo_o, ref_quo(as[ga], ad[ga]));
        end
        ga++;
      end
      if (chb_val_o) begin
        checks++;
        if (gb >= n) begin errors++; $display("FAIL stream_extra_b got %h exp none", chb_quo_o); end
        else if (chb_quo_o !== ref_quo(bs[gb], bd[gb])) begin
          errors++; $display("FAIL stream_quo_b[%0d] got %h exp %h", gb, chb_quo_o, ref_quo(bs[gb], bd[gb]));
        end
        gb++;
      end
      // Next operation is presented the cycle after the ack is seen.
      drv_a = (ia + (adv_a ? 0 : 0)) < n;
      drv_b = ib < n;
      cha_req_i = drv_a; if (drv_a) begin cha_sum_i = as[ia]; cha_dec_i = ad[ia]; end
      chb_req_i = drv_b; if (drv_b) begin chb_sum_i = bs[ib]; chb_dec_i = bd[ib]; end
      done = (ga == n) && (gb == n);
    end
    checks++; if (!done) begin errors++; $display("FAIL stream_timeout got a=%0d b=%0d exp %0d each", ga, gb, n); end
    checks++; if (acks != 2 * n) begin errors++; $display("FAIL stream_acks got %0d exp %0d", acks, 2 * n); end
    checks++; if (err_o !== 2'b00) begin errors++; $display("FAIL stream_err got %b exp 00", err_o); end
    if (chk_gap) begin
      for (int i = 1; i < go_cyc.size(); i++) begin
        checks++;
        if (go_cyc[i] - go_cyc[i-1] != 16) begin
          errors++; $display("FAIL stream_gap[%0d] got %0d exp 16", i, go_cyc[i] - go_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    run_stream(40, 5, 1'b1);
  endtask

  task automatic test_stall();
    run_stream(70, 4, 1'b0);
    checks++;
    if (go_cyc.size() < 5) begin
      errors++; $display("FAIL stall_issues got %0d exp >=5", go_cyc.size());
    end else if (go_cyc[4] - go_cyc[0] != 72) begin
      // Full FIFO until first result (issue+70); pop that cycle, issue next, go one later.
      errors++; $display("FAIL stall_fifth got %0d exp 72", go_cyc[4] - go_cyc[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_min_neg();
    test_zero_div();
    test_orphan();
    test_back_to_back();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
